// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply shift the input down the two-stage chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages reset to the line's idle level so no false edge is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling, one-cycle valid and
// framing-error strobes, single error for a held-low (break) line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Rx_Serial,
  output logic [DATA_W-1:0] Rx_Byte,
  output logic              Rx_DV,
  output logic              Rx_Frame_Err,
  output logic              Rx_Active
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

  logic rx_s;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              dv_q, dv_d;
  logic              ferr_q, ferr_d;
  logic              active_q, active_d;

  uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (Rx_Serial),
    .q    (rx_s)
  );

  // Next-state logic: framing FSM, bit-time counter and data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          // Still low at mid start bit: real frame; otherwise a glitch.
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEANUP:   state_d = IDLE;
      // Hold here through a break so it reports only one error.
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign Rx_Byte      = byte_q;
  assign Rx_DV        = dv_q;
  assign Rx_Frame_Err = ferr_q;
  assign Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, a
// negedge monitor pops and compares them as the receiver reports.
module tb_uart_rx;

  localparam int CPB  = 87;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;   // 829 for CPB = 87

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx_Serial = 1'b1;
  logic [7:0] Rx_Byte;
  logic       Rx_DV;
  logic       Rx_Frame_Err;
  logic       Rx_Active;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;    // expected report cycle, -1 = not checked
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         act_total = 0;
  logic [7:0] hold_byte = 8'h00;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rx_Serial   (Rx_Serial),
    .Rx_Byte     (Rx_Byte),
    .Rx_DV       (Rx_DV),
    .Rx_Frame_Err(Rx_Frame_Err),
    .Rx_Active   (Rx_Active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Send one frame; call at a negedge. Line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input int cpb, input bit stop_ok);
    exp_t e;
    logic v;
    e.is_err = !stop_ok;
    e.cyc    = (cpb == CPB) ? (cyc + 1 + LAT) : -1;
    if (stop_ok) begin
      e.data    = b;
      hold_byte = b;
    end else begin
      e.data = hold_byte;
    end
    sb_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_ok;
      else             v = b[i-1];
      Rx_Serial = v;
      repeat (cpb) @(negedge clk);
    end
  endtask

  // Monitor: pop and compare on every strobe, count active cycles.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (Rx_Active) act_total <= act_total + 1;
      if (Rx_DV || Rx_Frame_Err) begin
        chk("dv_err_exclusive", {31'd0, Rx_DV & Rx_Frame_Err}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", {31'd0, Rx_Frame_Err}, {31'd0, Rx_DV});
          chk("unexpected_strobe_any", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("strobe_kind_err", {31'd0, Rx_Frame_Err}, {31'd0, e.is_err});
          chk("rx_byte", {24'd0, Rx_Byte}, {24'd0, e.data});
          if (e.cyc >= 0) chk("strobe_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_byte",   {24'd0, Rx_Byte}, 32'h00);
    chk("reset_dv",     {31'd0, Rx_DV}, 32'd0);
    chk("reset_ferr",   {31'd0, Rx_Frame_Err}, 32'd0);
    chk("reset_active", {31'd0, Rx_Active}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_false_start", {31'd0, Rx_Active}, 32'd0);

    // 1: single frame, exact latency and active window
    a0 = act_total;
    send_byte(8'hA5, CPB, 1'b1);
    repeat (20) @(negedge clk);
    chk("active_cycles", act_total - a0, 1 + HALF + 9 * CPB);
    chk("active_low_after", {31'd0, Rx_Active}, 32'd0);

    // 2: back-to-back frames
    send_byte(8'h00, CPB, 1'b1);
    send_byte(8'hFF, CPB, 1'b1);
    send_byte(8'h3C, CPB, 1'b1);
    repeat (30) @(negedge clk);

    // 3: short low glitch, then a good frame
    Rx_Serial = 1'b0;
    repeat (20) @(negedge clk);
    Rx_Serial = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_idle", {31'd0, Rx_Active}, 32'd0);
    send_byte(8'h5A, CPB, 1'b1);
    repeat (30) @(negedge clk);

    // 4: bad stop bit followed by a long break, then recovery
    send_byte(8'h81, CPB, 1'b0);
    repeat (5000) @(negedge clk);
    chk("break_byte_held", {24'd0, Rx_Byte}, 32'h5A);
    Rx_Serial = 1'b1;
    repeat (30) @(negedge clk);
    send_byte(8'h42, CPB, 1'b1);
    repeat (30) @(negedge clk);

    // 5: reset in the middle of the data bits
    Rx_Serial = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("mid_frame_active", {31'd0, Rx_Active}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_byte",   {24'd0, Rx_Byte}, 32'h00);
    chk("midrst_dv",     {31'd0, Rx_DV}, 32'd0);
    chk("midrst_ferr",   {31'd0, Rx_Frame_Err}, 32'd0);
    chk("midrst_active", {31'd0, Rx_Active}, 32'd0);
    Rx_Serial = 1'b1;
    hold_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    send_byte(8'hC3, CPB, 1'b1);
    repeat (30) @(negedge clk);

    // 6: transmitter rate off by about 3% either way
    send_byte(8'h96, 84, 1'b1);
    repeat (100) @(negedge clk);
    send_byte(8'h96, 90, 1'b1);
    repeat (100) @(negedge clk);

    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
